// File: rtl/fp_pipe_stage_elastic.sv
// rtl/fp_pipe_stage_elastic.sv - elastic multi-stage register for the FP adder intermediate bundle
module fp_pipe_stage_elastic #(
    parameter int MW    = 24,
    parameter int SW    = 5,
    parameter int EW    = 8,
    parameter int DEPTH = 2,
    parameter int OCCW  = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [MW-1:0]   Z,
    input  logic [SW-1:0]   C,
    input  logic [EW-1:0]   ZE,
    input  logic            E,
    input  logic            AS,
    input  logic            BS,
    input  logic            ZS,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [MW-1:0]   Z1,
    output logic [SW-1:0]   C1,
    output logic [EW-1:0]   ZE1,
    output logic            E1,
    output logic            AS1,
    output logic            BS1,
    output logic            ZS1,
    output logic [OCCW-1:0] OCC
);

    localparam int PW = MW + SW + EW + 4;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [PW-1:0]    pay [DEPTH];
    logic [OCCW-1:0]  occ_q;
    logic [PW-1:0]    in_pay;
    logic             accept;
    logic             out_fire;

    // A stage stalls only when it and every stage after it hold data and the
    // output is blocked; this is the unrolled form of the back-to-front chain.
    for (genvar i = 0; i < DEPTH; i++) begin : g_adv
        if (i == DEPTH - 1) begin : g_last
            assign adv[i] = v[i] & OUT_READY;
        end else begin : g_mid
            assign adv[i] = v[i] & (OUT_READY | ~(&v[DEPTH-1:i+1]));
        end
    end

    assign in_pay   = {Z, C, ZE, E, AS, BS, ZS};
    assign IN_READY = ~FLUSH & (~v[0] | adv[0]);
    assign accept   = IN_VALID & IN_READY;
    assign out_fire = adv[DEPTH-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v     <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pay[i] <= '0;
            end
        end else if (FLUSH) begin
            // payload is deliberately kept; only the valid bits are dropped
            v     <= '0;
            occ_q <= '0;
        end else begin
            v[0] <= accept | (v[0] & ~adv[0]);
            if (accept) begin
                pay[0] <= in_pay;
            end
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= adv[i-1] | (v[i] & ~adv[i]);
                if (adv[i-1]) begin
                    pay[i] <= pay[i-1];
                end
            end
            occ_q <= occ_q + {{(OCCW-1){1'b0}}, accept} - {{(OCCW-1){1'b0}}, out_fire};
        end
    end

    assign OUT_VALID = v[DEPTH-1];
    assign {Z1, C1, ZE1, E1, AS1, BS1, ZS1} = pay[DEPTH-1];
    assign OCC = occ_q;

endmodule

// File: tb/tb_fp_pipe_stage_elastic.sv
// tb/tb_fp_pipe_stage_elastic.sv - scoreboard bench for fp_pipe_stage_elastic
module tb_fp_pipe_stage_elastic;

    localparam int MW = 24, SW = 5, EW = 8, D = 2, OCCW = 4;

    logic CLK = 1'b0, RST_N = 1'b0, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b1;
    logic [MW-1:0] Z = '0;
    logic [SW-1:0] C = '0;
    logic [EW-1:0] ZE = '0;
    logic E = 1'b0, AS = 1'b0, BS = 1'b0, ZS = 1'b0;
    logic IN_READY, OUT_VALID, E1, AS1, BS1, ZS1;
    logic [MW-1:0] Z1;
    logic [SW-1:0] C1;
    logic [EW-1:0] ZE1;
    logic [OCCW-1:0] OCC;

    logic iv_b = 1'b0, rdy_b = 1'b1, fl_b = 1'b0;
    logic ir_a, ov_a, e_a, as_a, bs_a, zs_a;
    logic [MW-1:0] z_a;
    logic [SW-1:0] c_a;
    logic [EW-1:0] ze_a;
    logic [OCCW-1:0] occ_a;
    logic ir_b, ov_b, e_b, as_b, bs_b, zs_b;
    logic [MW-1:0] z_b;
    logic [SW-1:0] c_b;
    logic [EW-1:0] ze_b;
    logic [OCCW-1:0] occ_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [MW-1:0] z;
        logic [SW-1:0] c;
        logic [EW-1:0] ze;
        logic e, sa, sb, sz;
        int t;
    } ent_t;
    ent_t q[$];

    fp_pipe_stage_elastic #(.MW(MW), .SW(SW), .EW(EW), .DEPTH(D), .OCCW(OCCW)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Z(Z), .C(C), .ZE(ZE), .E(E), .AS(AS), .BS(BS), .ZS(ZS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Z1(Z1), .C1(C1), .ZE1(ZE1), .E1(E1), .AS1(AS1), .BS1(BS1), .ZS1(ZS1), .OCC(OCC)
    );

    fp_pipe_stage_elastic #(.MW(MW), .SW(SW), .EW(EW), .DEPTH(1), .OCCW(OCCW)) dut_d1 (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(fl_b), .IN_VALID(iv_b), .IN_READY(ir_a),
        .Z(Z), .C(C), .ZE(ZE), .E(E), .AS(AS), .BS(BS), .ZS(ZS),
        .OUT_VALID(ov_a), .OUT_READY(rdy_b),
        .Z1(z_a), .C1(c_a), .ZE1(ze_a), .E1(e_a), .AS1(as_a), .BS1(bs_a), .ZS1(zs_a), .OCC(occ_a)
    );

    fp_pipe_stage_elastic #(.MW(MW), .SW(SW), .EW(EW), .DEPTH(8), .OCCW(OCCW)) dut_d8 (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(fl_b), .IN_VALID(iv_b), .IN_READY(ir_b),
        .Z(Z), .C(C), .ZE(ZE), .E(E), .AS(AS), .BS(BS), .ZS(ZS),
        .OUT_VALID(ov_b), .OUT_READY(rdy_b),
        .Z1(z_b), .C1(c_b), .ZE1(ze_b), .E1(e_b), .AS1(as_b), .BS1(bs_b), .ZS1(zs_b), .OCC(occ_b)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: FIFO of accepted bundles tagged with acceptance cycle.
    // The oldest entry is never blocked, so it is visible DEPTH cycles after
    // acceptance; the stage can take input whenever it is not full or the
    // output is being drained this cycle.
    always @(negedge CLK) begin
        bit exp_ov, exp_ir;
        if (!RST_N) begin
            q.delete();
        end else if (mon_en) begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].t + D);
            exp_ir = !FLUSH && ((q.size() < D) || (exp_ov && OUT_READY));
            chk("out_valid", 64'(OUT_VALID), 64'(exp_ov));
            chk("in_ready", 64'(IN_READY), 64'(exp_ir));
            chk("occ", 64'(OCC), 64'(q.size()));
            if (exp_ov) begin
                chk("payload", 64'({Z1, C1, ZE1, E1, AS1, BS1, ZS1}),
                    64'({q[0].z, q[0].c, q[0].ze, q[0].e, q[0].sa, q[0].sb, q[0].sz}));
                if (OUT_READY) void'(q.pop_front());
            end
            if (FLUSH) q.delete();
            else if (IN_VALID && exp_ir)
                q.push_back('{z: Z, c: C, ze: ZE, e: E, sa: AS, sb: BS, sz: ZS, t: cyc});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rnd_payload();
        Z  = MW'($urandom);
        C  = SW'($urandom);
        ZE = EW'($urandom);
        {E, AS, BS, ZS} = 4'($urandom);
    endtask

    initial begin
        logic [MW-1:0] pz [3];
        int n_acc;

        // reset then idle
        RST_N = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 64'(OUT_VALID), 64'(0));
        chk("rst_in_ready", 64'(IN_READY), 64'(1));
        chk("rst_occ", 64'(OCC), 64'(0));
        chk("rst_z1", 64'(Z1), 64'(0));
        chk("rst_ze1", 64'(ZE1), 64'(0));
        RST_N = 1'b1;
        step();
        chk("idle_out_valid", 64'(OUT_VALID), 64'(0));
        chk("idle_occ", 64'(OCC), 64'(0));
        mon_en = 1'b1;

        // latency and streaming with the two reference bundles
        OUT_READY = 1'b1;
        IN_VALID = 1'b1;
        Z = 24'h800001; C = 5'd3; ZE = 8'h7F; E = 1'b0; AS = 1'b0; BS = 1'b0; ZS = 1'b1;
        step();
        Z = 24'hC00000; C = 5'd0; ZE = 8'h80; ZS = 1'b0;
        step();
        IN_VALID = 1'b0;
        repeat (4) step();

        // back-pressure with a bubble behind the output entry
        IN_VALID = 1'b1; rnd_payload();
        step();
        IN_VALID = 1'b0;
        step();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; rnd_payload();
        step();
        rnd_payload();
        chk("bp_full_in_ready", 64'(IN_READY), 64'(0));
        repeat (4) step();
        OUT_READY = 1'b1;
        IN_VALID = 1'b0;
        repeat (4) step();

        // full pass-through
        IN_VALID = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            rnd_payload();
            #1;
            if (i >= 2) begin
                if (IN_READY) n_acc++;
                chk("pt_occ", 64'(OCC), 64'(D));
            end
            step();
        end
        chk("pt_accepts", 64'(n_acc), 64'(10));
        IN_VALID = 1'b0;
        repeat (3) step();

        // flush with two held entries and an offered input
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        rnd_payload(); step();
        rnd_payload(); step();
        FLUSH = 1'b1;
        rnd_payload();
        #1;
        chk("flush_in_ready", 64'(IN_READY), 64'(0));
        step();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush_occ", 64'(OCC), 64'(0));
        chk("flush_out_valid", 64'(OUT_VALID), 64'(0));
        OUT_READY = 1'b1;
        repeat (4) step();

        // asynchronous reset with two entries held
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        rnd_payload(); step();
        rnd_payload(); step();
        IN_VALID = 1'b0;
        chk("pre_arst_occ", 64'(OCC), 64'(2));
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_out_valid", 64'(OUT_VALID), 64'(0));
        chk("arst_occ", 64'(OCC), 64'(0));
        step();
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        step();

        // randomized traffic including occasional flush
        for (int i = 0; i < 800; i++) begin
            IN_VALID  = ($urandom_range(0, 9) < 7);
            OUT_READY = ($urandom_range(0, 9) < 6);
            FLUSH     = ($urandom_range(0, 29) == 0);
            rnd_payload();
            step();
        end
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        repeat (D + 2) step();

        // streaming latency at DEPTH=1 and DEPTH=8
        for (int i = 0; i < 3; i++) pz[i] = MW'($urandom);
        C = 5'd7; ZE = 8'h41; E = 1'b1; AS = 1'b0; BS = 1'b1; ZS = 1'b0;
        for (int n = 0; n < 14; n++) begin
            iv_b = (n < 3);
            if (n < 3) Z = pz[n];
            chk("d1_in_ready", 64'(ir_a), 64'(1));
            chk("d8_in_ready", 64'(ir_b), 64'(1));
            chk("d1_out_valid", 64'(ov_a), 64'(n >= 1 && n <= 3));
            chk("d8_out_valid", 64'(ov_b), 64'(n >= 8 && n <= 10));
            chk("d1_occ", 64'(occ_a), 64'(((n < 3) ? n : 3) - ((n - 1 < 0) ? 0 : ((n - 1 > 3) ? 3 : n - 1))));
            chk("d8_occ", 64'(occ_b), 64'(((n < 3) ? n : 3) - ((n - 8 < 0) ? 0 : ((n - 8 > 3) ? 3 : n - 8))));
            if (n >= 1 && n <= 3)
                chk("d1_payload", 64'({z_a, c_a, ze_a, e_a, as_a, bs_a, zs_a}),
                    64'({pz[n-1], 5'd7, 8'h41, 1'b1, 1'b0, 1'b1, 1'b0}));
            if (n >= 8 && n <= 10)
                chk("d8_payload", 64'({z_b, c_b, ze_b, e_b, as_b, bs_b, zs_b}),
                    64'({pz[n-8], 5'd7, 8'h41, 1'b1, 1'b0, 1'b1, 1'b0}));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
